// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared state encoding, frame constants and divider helper
// Even parity is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte handshake between the receive path and uart_tx_fifo
interface uart_tx_fifo_if;

  logic [7:0] char_in;
  logic       receive;
  logic       received;

  modport master (output char_in, output receive, input received);
  modport slave  (input char_in, input receive, output received);

endinterface

// File: rtl/uart_tx_fifo_sync_byte_fifo.sv
// rtl/uart_tx_fifo_sync_byte_fifo.sv - DEPTH x 8 synchronous FIFO, first-word fall-through
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [7:0]             wr_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter fed by the receive/received handshake
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_tx_fifo_if.slave               up,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int              DIV      = calc_div(CLK_HZ, BAUD);
  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_d;
  logic        received_q;
  logic        accept;
  logic        pop;
  logic        bit_end;
  logic [7:0]  rd_data;
  logic        full;
  logic        empty;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Fullness is the pre-pop value, so a push that coincides with a pop on a full FIFO waits a cycle.
  assign accept      = up.receive && !full && !received_q;
  assign up.received = received_q;
  assign bit_end     = (cnt_q == CNT_LAST);
  assign busy        = (state_q != S_IDLE) || !empty;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (accept),
    .wr_data (up.char_in),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rd_data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when data is waiting.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = rd_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_TX_PARITY_EN
    if (pop) parity_d = ^rd_data;
`endif

    // Restart the bit timer on every state entry so each bit lasts exactly DIV cycles.
    if ((state_q == S_IDLE) || (state_d != state_q) || bit_end) cnt_d = '0;
    else                                                      cnt_d = cnt_q + CW'(1);

    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      received_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      received_q <= accept;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo (DIV=16, depth 16)
module tb_uart_tx_fifo;

  localparam int CLK_HZ     = 16;
  localparam int BAUD       = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_level;
  int         checks = 0;
  int         errors = 0;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .up         (u_if),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    u_if.char_in = b;
    u_if.receive = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      seen = u_if.received;
    end
    chk("send_handshake", 32'(seen), 1);
    u_if.receive = 1'b0;
  endtask

  // Caller sits on the negedge just before the first start-bit sample.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [NBITS-1:0] bits;
    logic all1, any1;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9]   = ^b;
`endif
    for (int k = 0; k < NBITS; k++) begin
      all1 = 1'b1;
      any1 = 1'b0;
      repeat (DIV) begin
        @(negedge CLK);
        all1 &= tx;
        any1 |= tx;
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'({all1, any1}), 32'({bits[k], bits[k]}));
    end
    chk({tag, "_busy_last"}, 32'(busy), 1);
  endtask

  initial begin
    bit seen;
    int n;
    logic [4:0] prev_level;
    u_if.char_in = 8'h00;
    u_if.receive = 1'b0;

    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_tx", 32'(tx), 1);
      chk("rst_received", 32'(u_if.received), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_level", 32'(fifo_level), 0);
    end
    RST = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("idle_tx", 32'(tx), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_level", 32'(fifo_level), 0);
    end

    // Single byte with exact latency: tx falls one cycle after received rises.
    send(8'h41);
    chk("a41_level", 32'(fifo_level), 1);
    chk("a41_tx_pre", 32'(tx), 1);
    check_frame(8'h41, "a41");
    @(negedge CLK);
    chk("a41_busy_end", 32'(busy), 0);
    chk("a41_tx_end", 32'(tx), 1);
    chk("a41_received", 32'(u_if.received), 0);

    // Back-to-back frames with no idle cycle between them.
    fork
      begin
        send(8'h55);
        send(8'hAA);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge CLK);
          seen = u_if.received;
        end
        chk("b2b_sync", 32'(seen), 1);
        check_frame(8'h55, "b55");
        check_frame(8'hAA, "baa");
      end
    join
    @(negedge CLK);
    chk("b2b_busy_end", 32'(busy), 0);

    // Fill: first byte drains at once, next 16 fill the FIFO, 18th stalls until first STOP ends.
    for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
    chk("full_level", 32'(fifo_level), 16);
    u_if.char_in = 8'hEE;
    u_if.receive = 1'b1;
    n = 0;
    seen = 1'b0;
    prev_level = fifo_level;
    for (int i = 0; i < 300 && !seen; i++) begin
      prev_level = fifo_level;
      @(negedge CLK);
      n++;
      seen = u_if.received;
    end
    chk("stall_cycles", 32'(n), 130);
    chk("stall_level_pre", 32'(prev_level), 15);
    chk("stall_level_post", 32'(fifo_level), 16);
    u_if.receive = 1'b0;

    RST = 1'b1;
    @(negedge CLK);
    chk("rst2_tx", 32'(tx), 1);
    chk("rst2_level", 32'(fifo_level), 0);
    chk("rst2_busy", 32'(busy), 0);
    RST = 1'b0;

    // Reset in the middle of a 0xC3 frame with three bytes queued.
    send(8'hC3);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("mid_level", 32'(fifo_level), 3);
    repeat (44) @(negedge CLK);
    chk("mid_tx_bit2", 32'(tx), 0);
    RST = 1'b1;
    u_if.char_in = 8'h99;
    u_if.receive = 1'b1;
    @(negedge CLK);
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_received", 32'(u_if.received), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("held_received", 32'(u_if.received), 1);
    chk("held_level", 32'(fifo_level), 1);
    u_if.receive = 1'b0;
    check_frame(8'h99, "h99");
    @(negedge CLK);
    chk("h99_busy_end", 32'(busy), 0);
    chk("h99_level_end", 32'(fifo_level), 0);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    check_frame(8'h07, "p07");
    @(negedge CLK);
    chk("p07_busy_end", 32'(busy), 0);
    send(8'h03);
    check_frame(8'h03, "p03");
    @(negedge CLK);
    chk("p03_busy_end", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
